// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
//   pipe_state_e : sequencer state
//   stage_ctrl_t : PC enable plus per-stage enable/flush; bit 0 = IF/ID ... bit 3 = ME/WB
//   CTRL_*       : canned control words
//   ctrl_advance : controls for a cycle in which the pipeline is allowed to move
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] flush;
    } stage_ctrl_t;

    localparam int unsigned STG_IF_ID = 0;
    localparam int unsigned STG_ID_EX = 1;
    localparam int unsigned STG_EX_ME = 2;
    localparam int unsigned STG_ME_WB = 3;

    localparam stage_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b0000};
    // Hold PC..EX/ME; push a bubble into WB while the M-stage access is pending.
    localparam stage_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, en: 4'b1000, flush: 4'b1000};
    // Stop fetching and feed bubbles behind the last fetched instruction.
    localparam stage_ctrl_t CTRL_DRAIN  = '{pc_en: 1'b0, en: 4'b1111, flush: 4'b0001};
    localparam stage_ctrl_t CTRL_HALT   = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b0000};

    // Redirect outranks a RAW stall: the stalled instruction is on the wrong path anyway.
    function automatic stage_ctrl_t ctrl_advance(input logic redirect, input logic raw_stall);
        stage_ctrl_t c;
        c = CTRL_RUN;
        if (redirect) begin
            c.flush[STG_IF_ID] = 1'b1;
            c.flush[STG_ID_EX] = 1'b1;
        end else if (raw_stall) begin
            c.pc_en            = 1'b0;
            c.en[STG_IF_ID]    = 1'b0;
            c.flush[STG_ID_EX] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count enable
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Central pipeline sequencer: merges hazard, data-memory, debug-halt and perf-count
// requests into the PC enable and per-stage enable/flush controls.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   redirect_i, raw_stall_i : hazard unit requests
//   mem_req_i, mem_ack_i    : M-stage data memory handshake
//   halt_req_i, resume_i    : debug halt (level) / resume (pulse)
//   cnt_clr_i               : clear stall counter
//   pc_enable_o, *_enable_o, *_flush_o : pipeline controls (flush overrides enable)
//   halted_o                : pipeline empty and stopped
//   mem_err_o               : pulse when a data access is abandoned
//   stall_cnt_o             : saturating count of non-halted cycles with PC held
module pipe_ctrl_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             redirect_i,
    input  logic             raw_stall_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    input  logic             cnt_clr_i,
    output logic             pc_enable_o,
    output logic             if_id_enable_o,
    output logic             id_ex_enable_o,
    output logic             ex_me_enable_o,
    output logic             me_wb_enable_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_me_flush_o,
    output logic             me_wb_flush_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned        DRAIN_W     = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [7:0]         TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam bit                 TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    pipe_state_e        state_q, state_d;
    logic               halt_pend_q, halt_pend_d;
    logic               halt_block_q, halt_block_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    stage_ctrl_t ctrl;
    logic        mem_err;
    logic        halted;
    logic        mem_freeze;
    logic        halt_new;
    logic        stall_inc;

    assign mem_freeze = mem_req_i & ~mem_ack_i;
    // A halt level still present at resume is masked until it drops, so only a fresh
    // request can re-enter DRAIN.
    assign halt_new   = halt_req_i & ~halt_block_q;

    always_comb begin
        state_d      = state_q;
        halt_pend_d  = halt_pend_q;
        halt_block_d = halt_block_q & halt_req_i;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        ctrl         = CTRL_RUN;
        mem_err      = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_freeze) begin
                    // The EX branch/stall is held and re-presents after the access.
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                    if (halt_new) begin
                        halt_pend_d = 1'b1;
                    end
                end else begin
                    ctrl = ctrl_advance(redirect_i, raw_stall_i);
                    if (halt_new || halt_pend_q) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end

            MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (halt_new) begin
                    halt_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    ctrl        = ctrl_advance(redirect_i, raw_stall_i);
                    state_d     = (halt_pend_q || halt_new) ? DRAIN : RUN;
                    drain_cnt_d = '0;
                end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_VAL)) begin
                    // Abandon the access: clock a bubble into EX/ME, keep the front frozen.
                    ctrl                  = CTRL_FREEZE;
                    ctrl.en[STG_EX_ME]    = 1'b1;
                    ctrl.flush[STG_EX_ME] = 1'b1;
                    mem_err               = 1'b1;
                    state_d               = RUN;
                end else begin
                    ctrl = CTRL_FREEZE;
                end
            end

            DRAIN: begin
                if (mem_freeze) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl = CTRL_DRAIN;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = HALTED;
                        halt_pend_d = 1'b0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
            end

            HALTED: begin
                ctrl   = CTRL_HALT;
                halted = 1'b1;
                if (resume_i) begin
                    state_d      = RUN;
                    halt_block_d = halt_req_i;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs take their reset values as soon as reset asserts, not at the next edge.
        if (!rst_ni) begin
            ctrl    = CTRL_RUN;
            mem_err = 1'b0;
            halted  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            halt_pend_q  <= 1'b0;
            halt_block_q <= 1'b0;
            wait_cnt_q   <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            halt_pend_q  <= halt_pend_d;
            halt_block_q <= halt_block_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign stall_inc = ~ctrl.pc_en & (state_q != HALTED);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (cnt_clr_i),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    assign pc_enable_o    = ctrl.pc_en;
    assign if_id_enable_o = ctrl.en[STG_IF_ID];
    assign id_ex_enable_o = ctrl.en[STG_ID_EX];
    assign ex_me_enable_o = ctrl.en[STG_EX_ME];
    assign me_wb_enable_o = ctrl.en[STG_ME_WB];
    assign if_id_flush_o  = ctrl.flush[STG_IF_ID];
    assign id_ex_flush_o  = ctrl.flush[STG_ID_EX];
    assign ex_me_flush_o  = ctrl.flush[STG_EX_ME];
    assign me_wb_flush_o  = ctrl.flush[STG_ME_WB];
    assign halted_o       = halted;
    assign mem_err_o      = mem_err;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm (MEM_TIMEOUT=5, DRAIN_CYCLES=4, CNT_W=8).
// Control vector order: {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en,
//                        if_id_fl, id_ex_fl, ex_me_fl, me_wb_fl}
module tb_pipe_ctrl_fsm;

    localparam logic [8:0] C_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] C_FRZ   = 9'b0_0001_0001;
    localparam logic [8:0] C_REDIR = 9'b1_1111_1100;
    localparam logic [8:0] C_RAW   = 9'b0_0111_0100;
    localparam logic [8:0] C_TMO   = 9'b0_0011_0011;
    localparam logic [8:0] C_DRAIN = 9'b0_1111_1000;
    localparam logic [8:0] C_HALT  = 9'b0_0000_0000;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic redirect_i, raw_stall_i, mem_req_i, mem_ack_i;
    logic halt_req_i, resume_i, cnt_clr_i;
    logic pc_enable_o, if_id_enable_o, id_ex_enable_o, ex_me_enable_o, me_wb_enable_o;
    logic if_id_flush_o, id_ex_flush_o, ex_me_flush_o, me_wb_flush_o;
    logic halted_o, mem_err_o;
    logic [7:0] stall_cnt_o;
    logic [8:0] ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_fsm #(
        .DRAIN_CYCLES (4),
        .MEM_TIMEOUT  (5),
        .CNT_W        (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .redirect_i     (redirect_i),
        .raw_stall_i    (raw_stall_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .halt_req_i     (halt_req_i),
        .resume_i       (resume_i),
        .cnt_clr_i      (cnt_clr_i),
        .pc_enable_o    (pc_enable_o),
        .if_id_enable_o (if_id_enable_o),
        .id_ex_enable_o (id_ex_enable_o),
        .ex_me_enable_o (ex_me_enable_o),
        .me_wb_enable_o (me_wb_enable_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .ex_me_flush_o  (ex_me_flush_o),
        .me_wb_flush_o  (me_wb_flush_o),
        .halted_o       (halted_o),
        .mem_err_o      (mem_err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    assign ctl = {pc_enable_o, if_id_enable_o, id_ex_enable_o, ex_me_enable_o, me_wb_enable_o,
                  if_id_flush_o, id_ex_flush_o, ex_me_flush_o, me_wb_flush_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [8:0] exp);
        check(tag, {23'd0, ctl}, {23'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, stall_cnt_o}, {24'd0, exp});
    endtask

    // Leaves the bench 1 time unit after a rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        redirect_i  = 1'b0;
        raw_stall_i = 1'b0;
        mem_req_i   = 1'b0;
        mem_ack_i   = 1'b0;
        halt_req_i  = 1'b0;
        resume_i    = 1'b0;
        cnt_clr_i   = 1'b0;

        // Reset values
        #3;
        chk_ctl("rst_ctl", C_RUN);
        check("rst_halted", {31'd0, halted_o}, 32'd0);
        check("rst_err", {31'd0, mem_err_o}, 32'd0);
        chk_cnt("rst_cnt", 8'd0);
        tick();
        rst_ni = 1'b1;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            #2 chk_ctl("idle_ctl", C_RUN);
            tick();
        end
        #2 chk_cnt("idle_cnt", 8'd0);

        // Memory wait, ack on cycle 4
        mem_req_i = 1'b1;
        #2 chk_ctl("mem_c1", C_FRZ);
        tick();
        #2 chk_ctl("mem_c2", C_FRZ);
        tick();
        #2 chk_ctl("mem_c3", C_FRZ);
        tick();
        mem_ack_i = 1'b1;
        #2 chk_ctl("mem_ack", C_RUN);
        chk_cnt("mem_cnt", 8'd3);
        tick();
        mem_req_i = 1'b0;
        mem_ack_i = 1'b0;
        #2 chk_ctl("mem_after", C_RUN);
        chk_cnt("mem_cnt2", 8'd3);

        // Clear beats increment
        raw_stall_i = 1'b1;
        cnt_clr_i   = 1'b1;
        #2 chk_ctl("raw", C_RAW);
        tick();
        cnt_clr_i = 1'b0;
        #2 chk_cnt("clr_prio", 8'd0);
        tick();
        raw_stall_i = 1'b0;
        #2 chk_cnt("raw_inc", 8'd1);

        // Redirect + RAW in RUN, then during MEM_WAIT
        redirect_i  = 1'b1;
        raw_stall_i = 1'b1;
        #2 chk_ctl("redir_raw", C_REDIR);
        tick();
        mem_req_i = 1'b1;
        #2 chk_ctl("redir_frz1", C_FRZ);
        tick();
        #2 chk_ctl("redir_mw", C_FRZ);
        tick();
        mem_ack_i = 1'b1;
        #2 chk_ctl("redir_ack", C_REDIR);
        tick();
        redirect_i  = 1'b0;
        raw_stall_i = 1'b0;
        mem_req_i   = 1'b0;
        mem_ack_i   = 1'b0;
        #2 chk_ctl("redir_run", C_RUN);
        chk_cnt("redir_cnt", 8'd3);

        // Timeout after 5 wait cycles
        mem_req_i = 1'b1;
        #2 chk_ctl("to_entry", C_FRZ);
        tick();
        for (int i = 1; i < 5; i++) begin
            #2 chk_ctl("to_wait", C_FRZ);
            check("to_noerr", {31'd0, mem_err_o}, 32'd0);
            tick();
        end
        #2 chk_ctl("to_fire", C_TMO);
        check("to_err", {31'd0, mem_err_o}, 32'd1);
        tick();
        mem_req_i = 1'b0;
        #2 chk_ctl("to_run", C_RUN);
        check("to_err_off", {31'd0, mem_err_o}, 32'd0);
        chk_cnt("to_cnt", 8'd9);

        // Ack coinciding with the timeout cycle
        mem_req_i = 1'b1;
        tick();
        for (int i = 1; i < 5; i++) tick();
        mem_ack_i = 1'b1;
        #2 chk_ctl("ackto_ctl", C_RUN);
        check("ackto_noerr", {31'd0, mem_err_o}, 32'd0);
        tick();
        mem_req_i = 1'b0;
        mem_ack_i = 1'b0;
        #2 chk_ctl("ackto_run", C_RUN);
        chk_cnt("ackto_cnt", 8'd14);

        // Halt pulse during MEM_WAIT, ack two cycles later
        mem_req_i = 1'b1;
        tick();
        halt_req_i = 1'b1;
        #2 chk_ctl("hmw_frz", C_FRZ);
        tick();
        halt_req_i = 1'b0;
        tick();
        mem_ack_i = 1'b1;
        #2 chk_ctl("hmw_ack", C_RUN);
        tick();
        mem_req_i = 1'b0;
        mem_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            redirect_i = (i == 1);
            #2 chk_ctl("drain", C_DRAIN);
            check("drain_nohalt", {31'd0, halted_o}, 32'd0);
            tick();
        end
        redirect_i = 1'b0;
        #2 chk_ctl("halted_ctl", C_HALT);
        check("halted", {31'd0, halted_o}, 32'd1);
        chk_cnt("halt_cnt", 8'd21);
        tick();
        tick();
        #2 chk_cnt("halt_nocnt", 8'd21);
        resume_i = 1'b1;
        #2 chk_ctl("resume_cyc", C_HALT);
        tick();
        resume_i = 1'b0;
        #2 chk_ctl("resumed", C_RUN);
        check("resumed_halted", {31'd0, halted_o}, 32'd0);

        // Halt held across resume is edge-qualified
        halt_req_i = 1'b1;
        #2 chk_ctl("halt_run", C_RUN);
        tick();
        for (int i = 0; i < 4; i++) tick();
        #2 chk_ctl("halt2", C_HALT);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        #2 chk_ctl("hold_run1", C_RUN);
        tick();
        #2 chk_ctl("hold_run2", C_RUN);
        halt_req_i = 1'b0;
        tick();
        halt_req_i = 1'b1;
        #2 chk_ctl("reedge_run", C_RUN);
        tick();
        #2 chk_ctl("reedge_drain", C_DRAIN);
        halt_req_i = 1'b0;
        tick();

        // Asynchronous reset mid-DRAIN
        #2 chk_ctl("pre_rst", C_DRAIN);
        rst_ni = 1'b0;
        #1 chk_ctl("arst_ctl", C_RUN);
        check("arst_halted", {31'd0, halted_o}, 32'd0);
        chk_cnt("arst_cnt", 8'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        #2 chk_ctl("post_rst", C_RUN);
        check("post_rst_halted", {31'd0, halted_o}, 32'd0);

        // Saturation and clear
        raw_stall_i = 1'b1;
        repeat (260) tick();
        #2 chk_cnt("sat", 8'hff);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i   = 1'b0;
        raw_stall_i = 1'b0;
        #2 chk_cnt("sat_clr", 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
